// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator slice.
package pwm_pkg;

  // Duty double-buffer: EMPTY can take a new value, FULL holds one for the next wrap
  typedef enum logic {
    HS_EMPTY,
    HS_FULL
  } hs_state_t;

  // Dead-time insertion states
  typedef enum logic [2:0] {
    DT_OFF,
    DT_HI_WAIT,
    DT_HI,
    DT_LO_WAIT,
    DT_LO
  } dt_state_t;

  localparam int unsigned DEAD_CNT_W = 4;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion between the high and low side PWM outputs.
// Present only when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD = 2
) (
  input  logic Clk_in,
  input  logic Rst,
  input  logic pwm_raw,
  output logic Pwm_out,
  output logic Pwm_out_n
);

  localparam logic [DEAD_CNT_W-1:0] DEAD_CNT = DEAD_CNT_W'(DEAD);

  dt_state_t             state;
  dt_state_t             state_nxt;
  logic [DEAD_CNT_W-1:0] dcnt;
  logic [DEAD_CNT_W-1:0] dcnt_nxt;

  // State and dead counter register
  always_ff @(posedge Clk_in) begin
    if (!Rst) begin
      state <= DT_OFF;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next state: a side is only driven after DEAD cycles with both sides low;
  // a raw level that reverts before then is dropped and never reaches an output
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    case (state)
      DT_OFF: begin
        state_nxt = pwm_raw ? DT_HI_WAIT : DT_LO_WAIT;
        dcnt_nxt  = DEAD_CNT_W'(1);
      end
      DT_LO: begin
        if (pwm_raw) begin
          state_nxt = DT_HI_WAIT;
          dcnt_nxt  = DEAD_CNT_W'(1);
        end
      end
      DT_HI: begin
        if (!pwm_raw) begin
          state_nxt = DT_LO_WAIT;
          dcnt_nxt  = DEAD_CNT_W'(1);
        end
      end
      DT_HI_WAIT: begin
        if (!pwm_raw) begin
          state_nxt = DT_LO_WAIT;
          dcnt_nxt  = DEAD_CNT_W'(1);
        end else if (dcnt == DEAD_CNT) begin
          state_nxt = DT_HI;
        end else begin
          dcnt_nxt = dcnt + DEAD_CNT_W'(1);
        end
      end
      DT_LO_WAIT: begin
        if (pwm_raw) begin
          state_nxt = DT_HI_WAIT;
          dcnt_nxt  = DEAD_CNT_W'(1);
        end else if (dcnt == DEAD_CNT) begin
          state_nxt = DT_LO;
        end else begin
          dcnt_nxt = dcnt + DEAD_CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DT_OFF;
        dcnt_nxt  = '0;
      end
    endcase
  end

  // Outputs decode the registered state, so they are glitch-free
  always_comb begin
    Pwm_out   = (state == DT_HI);
    Pwm_out_n = (state == DT_LO);
  end

endmodule
`endif

// File: rtl/pwm_generator.sv
// PWM generator: period counter advanced by Pwm_clk rising edges, duty value
// double-buffered through a valid/ready handshake and applied at period wrap.
// Optional dead-time insertion when PWM_DEADTIME_EN is defined.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PERIOD = 10,
  parameter int unsigned DEAD   = 2
) (
  input  logic             Clk_in,
  input  logic             Rst,
  input  logic             Pwm_clk,
  input  logic [WIDTH-1:0] Duty,
  input  logic             Duty_valid,
  output logic             Duty_ready,
  output logic             Pwm_out,
  output logic             Pwm_out_n,
  output logic             Period_end
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(PERIOD - 1);

  if ((PERIOD < 2) || (64'(PERIOD) > (64'd1 << WIDTH)) || (DEAD < 1) || (DEAD > 15)) begin : g_cfg_check
    $error("pwm_generator: parameter out of range");
  end

  logic             pwm_clk_q;
  logic             tick;
  logic             wrap;
  logic             accept;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] pending;
  logic             pwm_raw;
  hs_state_t        hs_state;
  hs_state_t        hs_next;

  assign tick   = Pwm_clk & ~pwm_clk_q;
  assign wrap   = tick & (cnt == CNT_MAX);
  assign accept = Duty_valid & Duty_ready;

  // Pwm_clk edge detect and period counter; q resets high so a high Pwm_clk at release is not a tick
  always_ff @(posedge Clk_in) begin
    if (!Rst) begin
      pwm_clk_q <= 1'b1;
      cnt       <= '0;
    end else begin
      pwm_clk_q <= Pwm_clk;
      if (tick) begin
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + WIDTH'(1);
      end
    end
  end

  // Handshake state register
  always_ff @(posedge Clk_in) begin
    if (!Rst) begin
      hs_state <= HS_EMPTY;
    end else begin
      hs_state <= hs_next;
    end
  end

  // Handshake next state: ready is low while FULL, so accept and drain never overlap
  always_comb begin
    hs_next = hs_state;
    if (hs_state == HS_FULL) begin
      if (wrap) hs_next = HS_EMPTY;
    end else if (accept) begin
      hs_next = HS_FULL;
    end
  end

  // Handshake output
  always_comb begin
    Duty_ready = Rst & (hs_state == HS_EMPTY);
  end

  // Duty double buffer: pending captured on accept, promoted only at a wrap
  always_ff @(posedge Clk_in) begin
    if (!Rst) begin
      pending  <= '0;
      duty_act <= '0;
    end else begin
      if (accept) pending <= Duty;
      if (wrap && (hs_state == HS_FULL)) duty_act <= pending;
    end
  end

  // Compare and period-end pulse; unsigned compare saturates high when duty >= PERIOD
  always_ff @(posedge Clk_in) begin
    if (!Rst) begin
      pwm_raw    <= 1'b0;
      Period_end <= 1'b0;
    end else begin
      pwm_raw    <= (cnt < duty_act);
      Period_end <= wrap;
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(
    .DEAD (DEAD)
  ) u_deadtime (
    .Clk_in    (Clk_in),
    .Rst       (Rst),
    .pwm_raw   (pwm_raw),
    .Pwm_out   (Pwm_out),
    .Pwm_out_n (Pwm_out_n)
  );
`else
  logic out_n_en;

  // Keeps the low side off through reset and its first following cycle
  always_ff @(posedge Clk_in) begin
    if (!Rst) begin
      out_n_en <= 1'b0;
    end else begin
      out_n_en <= 1'b1;
    end
  end

  // Direct complementary outputs
  always_comb begin
    Pwm_out   = pwm_raw;
    Pwm_out_n = out_n_en & ~pwm_raw;
  end
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Directed self-checking bench for pwm_generator (WIDTH=8, PERIOD=10).
// Pwm_clk toggles every 4 Clk_in cycles, so one tick per 8 cycles and 80 cycles per period.
// Covers the PWM_DEADTIME_EN build as well when that macro is defined.
module tb_pwm_generator;

  logic       Clk_in = 1'b0;
  logic       Rst;
  logic       Pwm_clk;
  logic [7:0] Duty;
  logic       Duty_valid;
  logic       Duty_ready;
  logic       Pwm_out;
  logic       Pwm_out_n;
  logic       Period_end;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit          pwm_run;
  int unsigned div;
  int unsigned w_high, w_n_high, w_pe, w_trans, w_bad;
  int unsigned pe_steps;

  always #5 Clk_in = ~Clk_in;

  pwm_generator #(
    .WIDTH  (8),
    .PERIOD (10),
    .DEAD   (2)
  ) dut (
    .Clk_in     (Clk_in),
    .Rst        (Rst),
    .Pwm_clk    (Pwm_clk),
    .Duty       (Duty),
    .Duty_valid (Duty_valid),
    .Duty_ready (Duty_ready),
    .Pwm_out    (Pwm_out),
    .Pwm_out_n  (Pwm_out_n),
    .Period_end (Period_end)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One Clk_in cycle: advance to the falling edge, then move the Pwm_clk divider
  task automatic step();
    @(negedge Clk_in);
    if (pwm_run) begin
      if (div == 3) begin
        div     = 0;
        Pwm_clk = ~Pwm_clk;
      end else begin
        div++;
      end
    end
  endtask

  // Sample n cycles and tally output behaviour
  task automatic window(input int unsigned n);
    logic prev;
    prev     = Pwm_out;
    w_high   = 0;
    w_n_high = 0;
    w_pe     = 0;
    w_trans  = 0;
    w_bad    = 0;
    for (int unsigned i = 0; i < n; i++) begin
      step();
      if (Pwm_out)         w_high++;
      if (Pwm_out_n)       w_n_high++;
      if (Period_end)      w_pe++;
      if (Pwm_out != prev) w_trans++;
`ifdef PWM_DEADTIME_EN
      if (Pwm_out && Pwm_out_n) w_bad++;
`else
      if (Pwm_out == Pwm_out_n) w_bad++;
`endif
      prev = Pwm_out;
    end
  endtask

  task automatic wait_pe();
    bit found;
    found    = 1'b0;
    pe_steps = 0;
    for (int unsigned i = 0; i < 300 && !found; i++) begin
      step();
      pe_steps++;
      if (Period_end) found = 1'b1;
    end
    chk("wait_pe", found, 1);
  endtask

  // Load a duty at a period boundary and skip the rest of the current period
  task automatic load_duty(input int unsigned d);
    Duty       = 8'(d);
    Duty_valid = 1'b1;
    chk("ld_ready", Duty_ready, 1);
    step();
    Duty_valid = 1'b0;
    window(79);
  endtask

  initial begin
    Rst        = 1'b0;
    Pwm_clk    = 1'b0;
    Duty       = '0;
    Duty_valid = 1'b0;
    pwm_run    = 1'b0;
    div        = 0;
    repeat (3) step();
    chk("rst_ready", Duty_ready, 0);
    chk("rst_out", Pwm_out, 0);
    chk("rst_out_n", Pwm_out_n, 0);
    chk("rst_pe", Period_end, 0);

    Rst = 1'b1;
    step();
    chk("rel_ready", Duty_ready, 1);
    chk("rel_out", Pwm_out, 0);
`ifndef PWM_DEADTIME_EN
    chk("rel_out_n", Pwm_out_n, 1);
`endif

    Duty       = 8'd3;
    Duty_valid = 1'b1;
    step();
    chk("ready_drop", Duty_ready, 0);
    Duty_valid = 1'b0;
    pwm_run    = 1'b1;
    div        = 0;
    wait_pe();

`ifdef PWM_DEADTIME_EN
    for (int unsigned p = 0; p < 2; p++) begin
      window(80);
      chk("dt_high", w_high, 22);
      chk("dt_low_side", w_n_high, 54);
      chk("dt_overlap", w_bad, 0);
      chk("dt_pe", w_pe, 1);
    end
`else
    // Duty 3: 24 high cycles per 80, one Period_end at the period end
    for (int unsigned p = 0; p < 2; p++) begin
      window(80);
      chk("d3_high", w_high, 24);
      chk("d3_trans", w_trans, 2);
      chk("d3_pe", w_pe, 1);
      chk("d3_pe_last", Period_end, 1);
      chk("d3_compl", w_bad, 0);
    end

    // Mid-period change to 7, then 5 held while not ready
    window(20);
    chk("mid_high_a", w_high, 20);
    Duty       = 8'd7;
    Duty_valid = 1'b1;
    chk("mid_ready", Duty_ready, 1);
    step();
    chk("mid_full", Duty_ready, 0);
    Duty = 8'd5;
    window(59);
    chk("mid_high_b", w_high, 3);
    chk("mid_pe", w_pe, 1);
    chk("held_ready", Duty_ready, 1);
    step();
    chk("held_acc", Duty_ready, 0);
    chk("d7_first", Pwm_out, 1);
    Duty_valid = 1'b0;
    window(79);
    chk("d7_high", w_high, 55);
    chk("d7_pe", w_pe, 1);
    window(80);
    chk("d5_high", w_high, 40);
    chk("d5_trans", w_trans, 2);

    // Accept in the exact wrap cycle: takes effect one period later
    window(79);
    chk("d5b_high", w_high, 40);
    Duty       = 8'd2;
    Duty_valid = 1'b1;
    step();
    chk("wrap_pe", Period_end, 1);
    chk("wrap_acc", Duty_ready, 0);
    Duty_valid = 1'b0;
    window(80);
    chk("wrap_old", w_high, 40);
    window(80);
    chk("wrap_new", w_high, 16);

    // Saturation boundaries
    load_duty(0);
    window(80);
    chk("d0_high", w_high, 0);
    chk("d0_trans", w_trans, 0);
    load_duty(10);
    window(80);
    chk("d10_high", w_high, 80);
    chk("d10_trans", w_trans, 1);
    load_duty(200);
    window(80);
    chk("d200_high", w_high, 80);
    chk("d200_trans", w_trans, 0);
    chk("d200_compl", w_bad, 0);

    // Reset mid-period with a pending value, Pwm_clk high across release
    Duty       = 8'd3;
    Duty_valid = 1'b1;
    step();
    Duty_valid = 1'b0;
    window(30);
    chk("pre_rst_full", Duty_ready, 0);
    Rst     = 1'b0;
    pwm_run = 1'b0;
    Pwm_clk = 1'b1;
    step();
    chk("mrst_out", Pwm_out, 0);
    chk("mrst_out_n", Pwm_out_n, 0);
    chk("mrst_pe", Period_end, 0);
    chk("mrst_ready", Duty_ready, 0);
    Rst = 1'b1;
    step();
    chk("mrel_ready", Duty_ready, 1);
    chk("mrel_out_n", Pwm_out_n, 1);
    window(20);
    chk("hold_pe", w_pe, 0);
    chk("hold_high", w_high, 0);
    Pwm_clk = 1'b0;
    div     = 0;
    pwm_run = 1'b1;
    wait_pe();
    chk("first_wrap_dly", pe_steps, 77);
    window(80);
    chk("pend_lost", w_high, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
